// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and byte sequencer sharing one UART TX serializer
// among NUM_REQ requesters; words of 1-4 bytes are sent LSB first.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  input  logic [2*NUM_REQ-1:0] req_len,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   word_done,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_sdata,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

  state_t            state, state_n;
  logic [31:0]       data_q, data_n;
  logic [1:0]        len_q, len_n;
  logic [1:0]        idx_q, idx_n, idx_inc;
  logic [1:0]        owner_q, owner_n;
  logic [1:0]        ptr_q, ptr_n;
  logic [TW-1:0]     tmo_q, tmo_n;
  logic [NUM_REQ-1:0] ready_n, done_n, grant_n;
  logic [7:0]        sdata_n;
  logic              start_n, err_n;

  logic              found;
  logic [1:0]        win;
  logic [31:0]       win_data;
  logic [1:0]        win_len;
  logic              busy_tmo, last_byte;

  assign busy_tmo  = !tx_busy && (tmo_q == TW'(BUSY_TIMEOUT - 1));
  assign last_byte = (idx_q == len_q);
  assign idx_inc   = idx_q + 2'd1;

  // Cyclic search: first pass covers indices at/after the pointer, second wraps.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    win_len  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i >= 32'(ptr_q))) begin
        found = 1'b1;
        win   = 2'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        win   = 2'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == 2'(i)) begin
        win_data = req_data[32*i +: 32];
        win_len  = req_len[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      tmo_q     <= '0;
      req_ready <= '0;
      word_done <= '0;
      grant     <= '0;
      tx_sdata  <= '0;
      tx_start  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      data_q    <= data_n;
      len_q     <= len_n;
      idx_q     <= idx_n;
      owner_q   <= owner_n;
      ptr_q     <= ptr_n;
      tmo_q     <= tmo_n;
      req_ready <= ready_n;
      word_done <= done_n;
      grant     <= grant_n;
      tx_sdata  <= sdata_n;
      tx_start  <= start_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (found) state_n = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)       state_n = WAIT_DONE;
        else if (busy_tmo) state_n = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_n = last_byte ? IDLE : WAIT_BUSY;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    data_n  = data_q;
    len_n   = len_q;
    idx_n   = idx_q;
    owner_n = owner_q;
    ptr_n   = ptr_q;
    tmo_n   = tmo_q;
    ready_n = '0;
    done_n  = '0;
    grant_n = grant;
    sdata_n = tx_sdata;
    start_n = 1'b0;
    err_n   = err;
    unique case (state)
      IDLE: begin
        if (found) begin
          data_n  = win_data;
          len_n   = win_len;
          idx_n   = '0;
          owner_n = win;
          tmo_n   = '0;
          sdata_n = win_data[7:0];
          start_n = 1'b1;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_n[i] = (win == 2'(i));
            ready_n[i] = (win == 2'(i));
          end
        end
      end
      WAIT_BUSY: begin
        if (!tx_busy) begin
          if (busy_tmo) begin
            err_n   = 1'b1;
            grant_n = '0;
          end else begin
            tmo_n = tmo_q + TW'(1);
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_byte) begin
            for (int unsigned i = 0; i < NUM_REQ; i++)
              done_n[i] = (owner_q == 2'(i));
            grant_n = '0;
            ptr_n   = (owner_q == 2'(NUM_REQ - 1)) ? 2'd0 : owner_q + 2'd1;
          end else begin
            idx_n   = idx_inc;
            sdata_n = data_q[{idx_inc, 3'b000} +: 8];
            start_n = 1'b1;
            tmo_n   = '0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requesters, a serializer model and a
// transaction-level reference of arbitration order and byte stream.
module tb_uart_tx_arbiter;
  localparam int N   = 3;
  localparam int TMO = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_data;
  logic [2*N-1:0]  req_len;
  logic [N-1:0]    req_ready, word_done, grant;
  logic [7:0]      tx_sdata;
  logic            tx_start;
  logic            tx_busy;
  logic            err;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_len(req_len), .req_ready(req_ready), .word_done(word_done),
    .grant(grant), .tx_sdata(tx_sdata), .tx_start(tx_start),
    .tx_busy(tx_busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // requester side
  logic [31:0] rq_data [N];
  logic [1:0]  rq_len  [N];
  logic [N-1:0] rq_valid;
  logic [N-1:0] v_prev;
  logic [N-1:0] act_mask;
  int load, max_len;

  // reference: word in flight, pointer, sticky error, scheduled events
  int ptr_m, owner, w_len, w_idx;
  bit in_flight, err_m, dead;
  logic [31:0] w_data;
  int done_cyc, start_cyc, dead_cyc;

  // serializer model
  bit ser_pend;
  int ser_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_data[32*i +: 32] = rq_data[i];
      req_len[2*i +: 2]    = rq_len[i];
    end
    req_valid = rq_valid;
    v_prev    = rq_valid;
  endtask

  task automatic present(input int i, input logic [31:0] d, input int l);
    rq_valid[i] = 1'b1;
    rq_data[i]  = d;
    rq_len[i]   = 2'(l);
    drive_inputs();
  endtask

  task automatic new_word(input int i);
    rq_valid[i] = 1'b1;
    rq_data[i]  = $urandom;
    rq_len[i]   = 2'($urandom_range(max_len, 0));
  endtask

  task automatic clear_model();
    in_flight = 0; ptr_m = 0; err_m = 0; owner = 0; w_idx = 0; w_len = 0;
    done_cyc = -1; start_cyc = -1; dead_cyc = -1;
    ser_pend = 0; ser_cnt = 0; tx_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq_valid[i] = 1'b0; rq_data[i] = '0; rq_len[i] = '0;
    end
    drive_inputs();
  endtask

  task automatic step();
    int win;
    bit acc, done, tmo, nxt;
    logic [N-1:0] exp_grant;
    logic [7:0] exp_byte;
    @(negedge clk);
    cyc++;
    win  = (!in_flight && v_prev != '0) ? rr_pick(v_prev, ptr_m) : -1;
    acc  = (win >= 0);
    done = in_flight && (cyc == done_cyc);
    tmo  = in_flight && (cyc == dead_cyc);
    nxt  = in_flight && (cyc == start_cyc);
    if (tmo) err_m = 1;
    exp_byte = '0;
    if (acc) exp_byte = rq_data[win][7:0];
    else if (nxt) exp_byte = 8'(w_data >> (8 * (w_idx + 1)));
    if (acc) exp_grant = onehot(win);
    else if (done || tmo || !in_flight) exp_grant = '0;
    else exp_grant = onehot(owner);

    check("req_ready", req_ready, onehot(win));
    check("word_done", word_done, done ? onehot(owner) : '0);
    check("grant", grant, exp_grant);
    check("tx_start", tx_start, acc || nxt);
    if (acc || nxt) check("tx_sdata", tx_sdata, exp_byte);
    check("err", err, err_m);

    if (acc) begin
      in_flight = 1; owner = win; w_data = rq_data[win]; w_len = rq_len[win]; w_idx = 0;
      if (dead) dead_cyc = cyc + TMO;
    end
    if (nxt) w_idx++;
    if (done) begin
      in_flight = 0;
      ptr_m = (owner + 1) % N;
    end
    if (tmo) in_flight = 0;

    if (ser_pend) begin
      tx_busy = 1'b1; ser_cnt = $urandom_range(6, 1); ser_pend = 0;
    end else if (tx_busy) begin
      ser_cnt--;
      if (ser_cnt == 0) begin
        tx_busy = 1'b0;
        if (w_idx == w_len) done_cyc = cyc + 1;
        else start_cyc = cyc + 1;
      end
    end
    if (tx_start && !dead) ser_pend = 1;

    for (int i = 0; i < N; i++) begin
      if (acc && win == i) begin
        if (act_mask[i] && $urandom_range(99, 0) < load) new_word(i);
        else rq_valid[i] = 1'b0;
      end else if (!rq_valid[i]) begin
        if (act_mask[i] && $urandom_range(99, 0) < load) new_word(i);
        else rq_data[i] = $urandom;
      end
    end
    drive_inputs();
  endtask

  initial begin
    bit reached;
    dead = 0; load = 0; max_len = 3; act_mask = '1;
    clear_model();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, '0);
    check("rst_word_done", word_done, '0);
    check("rst_grant", grant, '0);
    check("rst_tx_sdata", tx_sdata, '0);
    check("rst_tx_start", tx_start, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    present(0, 32'h0000_00A5, 0);
    repeat (30) step();
    present(1, 32'h4433_2211, 3);
    repeat (80) step();

    // both requesters continuously valid with single-byte words
    act_mask = 3'b011; load = 100; max_len = 0;
    present(0, $urandom, 0);
    present(1, $urandom, 0);
    repeat (80) step();
    load = 0;
    repeat (40) step();

    act_mask = '1; load = 30; max_len = 3;
    repeat (1500) step();
    load = 0;
    repeat (80) step();

    // serializer never answers: timeout, then sticky err through later words
    dead = 1;
    present(2, $urandom, 1);
    repeat (12) step();
    dead = 0; load = 20;
    repeat (300) step();
    load = 0;
    repeat (80) step();

    // reset during the second byte of a four-byte word
    reached = 0;
    present(0, $urandom, 3);
    for (int k = 0; k < 200 && !reached; k++) begin
      step();
      if (in_flight && w_idx == 1 && tx_busy) reached = 1;
    end
    check("midword_reached", reached, 1);
    #2 rst = 1'b1;
    #1;
    check("async_grant", grant, '0);
    check("async_tx_start", tx_start, 0);
    check("async_tx_sdata", tx_sdata, '0);
    check("async_err", err, 0);
    check("async_req_ready", req_ready, '0);
    check("async_word_done", word_done, '0);
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    present(0, $urandom, 2);
    repeat (60) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and byte sequencer that shares one `uart_tx` serializer among `NUM_REQ` requesters. Each requester hands over a word of 1–4 bytes with a valid/ready handshake. The block grants one requester at a time and drives the serializer's `sdata`/`tx_start` byte by byte, LSB first, pacing on `tx_busy`. It sits between the core/debug output sources and the single UART TX pin.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2–4.
- `BUSY_TIMEOUT`, default 4: maximum cycles to wait for `tx_busy` to rise after `tx_start`.
- `clk` in, 1 bit: sole clock.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `req_valid` in, `NUM_REQ` bits: requester i has a word pending; held until `req_ready[i]` is seen.
- `req_data` in, `32*NUM_REQ` bits: word of requester i in bits [32i+31:32i].
- `req_len` in, `2*NUM_REQ` bits: byte count minus 1 for requester i (0 means 1 byte, 3 means 4 bytes).
- `req_ready` out, `NUM_REQ` bits: one-cycle pulse when requester i's word is latched.
- `word_done` out, `NUM_REQ` bits: one-cycle pulse when requester i's last byte has finished on the line.
- `grant` out, `NUM_REQ` bits: one-hot current owner; all zero when idle.
- `tx_sdata` out, 8 bits: byte to the serializer.
- `tx_start` out, 1 bit: one-cycle start pulse to the serializer.
- `tx_busy` in, 1 bit: serializer busy. It rises one cycle after an accepted `tx_start` and falls after the stop bit.
- `err` out, 1 bit: sticky timeout flag, cleared only by `rst`.

## Operation
- All outputs are registered.
- Reset values: `req_ready`, `word_done`, `grant`, `tx_sdata`, `tx_start` and `err` are all 0. State is IDLE. The priority pointer is 0.
- The FSM has three states: IDLE, WAIT_BUSY and WAIT_DONE.
- IDLE:
  - When any `req_valid` is high, the winner is the first valid index at or after the pointer, searching cyclically.
  - On that edge the block latches the winner's data and length and clears `byte_idx` to 0.
  - It also sets `grant` to the winner (one-hot), `req_ready[winner]`=1, `tx_sdata`=data[7:0] and `tx_start`=1, then moves to WAIT_BUSY.
- WAIT_BUSY:
  - `tx_start` returns to 0.
  - When `tx_busy`=1 the FSM moves to WAIT_DONE.
  - If `BUSY_TIMEOUT` cycles elapse without `tx_busy`, the block sets `err`=1, abandons the word, clears `grant`, moves to IDLE and does not pulse `word_done`.
- WAIT_DONE, on `tx_busy`=0:
  - If `byte_idx`==len: pulse `word_done[owner]`, clear `grant`, set the pointer to (owner+1) mod `NUM_REQ`, and move to IDLE.
  - Otherwise: increment `byte_idx`, set `tx_sdata` = byte `byte_idx`+1 of the latched word, pulse `tx_start`=1, and move to WAIT_BUSY.
- `req_valid`, `req_data` and `req_len` are ignored outside IDLE. Changes to them after latching do not affect the word in flight.
- The pointer is updated only on normal completion. A timeout leaves the pointer unchanged, so the same requester wins again if it still has a word pending.
- Byte selection is `byte_idx`*8 into the latched word. `byte_idx` is 2 bits and never wraps past len.

## Timing
- Latency from `req_valid` being sampled in IDLE to `tx_start`/`req_ready` high is 1 cycle.
- The requester sees `req_ready` in the cycle after the latch edge. It must drop `req_valid` or present its next word on the following edge.
- No double accept can occur, because the FSM cannot be in IDLE within 2 cycles of an accept.
- `tx_start` is high for exactly 1 cycle per byte.
- Between bytes, `tx_start` for the next byte is asserted on the edge after `tx_busy` is sampled low. The serializer is idle at that point and accepts it.
- `word_done` is asserted on the edge after the last `tx_busy` fall. The next arbitration can occur on the following edge, so the inter-word gap is 1 idle cycle.
- When several requesters are valid in the same cycle, only the winner gets `req_ready`; the others keep waiting.
- When `rst` is asserted mid-word, all outputs clear immediately without waiting for a clock, and the partial word is dropped.
  - The serializer has its own reset and may still finish the current frame.
  - After release, the first `tx_busy` fall seen in IDLE is ignored.

## Test plan
- Single byte: req0 valid, data=0x000000A5, len=0.
  - Expect `req_ready[0]` for 1 cycle, then `tx_sdata`=0xA5 with `tx_start` pulsed once.
  - Expect `word_done[0]` 1 cycle after `tx_busy` falls, and `grant` returning to 0.
- Four-byte word: req1, data=0x44332211, len=3.
  - Expect four `tx_start` pulses with `tx_sdata` of 0x11, 0x22, 0x33 and 0x44 in that order.
  - Expect exactly one `word_done[1]`, after the fourth frame.
- Round-robin: req0 and req1 both continuously valid with len=0.
  - Expect grants in the order 0, 1, 0, 1.
  - Neither requester is granted twice in a row while the other is pending.
- Timeout: a bench model that never raises `tx_busy`.
  - Expect `err`=1 exactly `BUSY_TIMEOUT`(4) cycles after `tx_start`, then `grant`=0 and no `word_done`.
  - Expect `err` to stay 1 through later words until `rst`.
- Reset mid-word: assert `rst` during byte 2 of a len=3 word.
  - Expect `grant`, `tx_start`, `err` and `tx_sdata` to be 0 without waiting for a clock edge.
  - After release, a new req0 word is accepted from byte 0.
- Input stability: change `req_data` of the granted requester during WAIT_DONE.
  - Expect the remaining bytes to still come from the latched word.
